fu_issue_sched: RTL and testbench

//  Issue scheduler for the shared func_units datapath.
//  - Picks at most one of the ALU RS and the LS RS each cycle and drives that unit's start.
//  - Reserves the single ROB writeback slot so ALU and LS results never collide.
//  - Drives done/ROB-index to the ROB from its own tag pipeline.
//  - Sits between both reservation stations and func_units/ROB.

---
 rtl/fu_issue_sched_pkg.sv | 10 +
 rtl/fu_issue_sched_wb_slot_tracker.sv | 55 +++++
 rtl/fu_issue_sched.sv | 88 ++++++++
 tb/tb_fu_issue_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fu_issue_sched_pkg.sv
// Shared types and default latencies for the functional-unit issue scheduler.
package fu_issue_sched_pkg;

   typedef enum logic {FU_SEL_ALU, FU_SEL_LS} fu_sel_t;

   localparam int FU_ALU_LAT   = 1;
   localparam int FU_LS_LAT    = 2;
   localparam int ROB_IDX_SIZE = 5;

endpackage

// File: rtl/fu_issue_sched_wb_slot_tracker.sv
// Writeback-slot reservation pipeline: a shifting occupancy vector plus the ROB
// index riding along with each occupied slot.
module fu_issue_sched_wb_slot_tracker #(
   parameter int DEPTH  = 2,
   parameter int IDX_W  = 5,
   parameter int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set,
   input  logic [SLOT_W-1:0] set_slot,
   input  logic [IDX_W-1:0]  set_idx,
   input  logic              flush,
   output logic [DEPTH-1:0]  slot_free,
   output logic              done,
   output logic [IDX_W-1:0]  idx
);

   logic [DEPTH-1:0]            resv;
   logic [DEPTH-1:0]            resv_next;
   logic [DEPTH-1:0][IDX_W-1:0] tag;
   logic [DEPTH-1:0][IDX_W-1:0] tag_next;

   // slot_free[k]: a set into slot k at the coming edge would not collide
   // with an already reserved writeback shifting down into that slot.
   assign slot_free = ~(resv >> 1);
   assign done      = resv[0];
   assign idx       = tag[0];

   always_comb begin
      resv_next = resv >> 1;
      tag_next  = '0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         tag_next[k] = tag[k+1];
      end
      if (set) begin
         resv_next[set_slot] = 1'b1;
         tag_next[set_slot]  = set_idx;
      end
      if (flush) begin
         resv_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resv <= '0;
         tag  <= '0;
      end else begin
         resv <= resv_next;
         tag  <= tag_next;
      end
   end

endmodule

// File: rtl/fu_issue_sched.sv
// Issue arbiter between the ALU and LS reservation stations; guarantees the
// single ROB writeback bus is never claimed by both units in the same cycle.
module fu_issue_sched
   import fu_issue_sched_pkg::*;
#(
   parameter int ALU_LAT   = FU_ALU_LAT,
   parameter int LS_LAT    = FU_LS_LAT,
   parameter int ROB_IDX_W = ROB_IDX_SIZE
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic                 in_rs_alu_req,
   input  logic [ROB_IDX_W-1:0] in_rs_alu_rob_idx,
   input  logic                 in_rs_ls_req,
   input  logic [ROB_IDX_W-1:0] in_rs_ls_rob_idx,
   input  logic                 in_flush,
   output logic                 out_rs_alu_grant,
   output logic                 out_rs_ls_grant,
   output logic                 out_rob_done,
   output logic [ROB_IDX_W-1:0] out_rob_dst_rob_index
);

   localparam int MAX_LAT = (ALU_LAT > LS_LAT) ? ALU_LAT : LS_LAT;
   localparam int SLOT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   fu_sel_t              ptr;
   logic [MAX_LAT-1:0]   slot_free;
   logic                 alu_ok;
   logic                 ls_ok;
   logic                 grant_alu;
   logic                 grant_ls;
   logic                 set;
   logic [SLOT_W-1:0]    set_slot;
   logic [ROB_IDX_W-1:0] set_idx;

   assign alu_ok = slot_free[ALU_LAT-1];
   assign ls_ok  = slot_free[LS_LAT-1];

   // A favoured unit that is blocked yields a bubble rather than the other
   // unit, so a long-latency unit cannot be starved by a short one.
   always_comb begin
      grant_alu = 1'b0;
      grant_ls  = 1'b0;
      if (in_rst_n && !in_flush) begin
         if (ptr == FU_SEL_ALU) begin
            if (in_rs_alu_req) grant_alu = alu_ok;
            else               grant_ls  = in_rs_ls_req && ls_ok;
         end else begin
            if (in_rs_ls_req)  grant_ls  = ls_ok;
            else               grant_alu = in_rs_alu_req && alu_ok;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         ptr <= FU_SEL_ALU;
      end else if (grant_alu && in_rs_ls_req) begin
         ptr <= FU_SEL_LS;
      end else if (grant_ls && in_rs_alu_req) begin
         ptr <= FU_SEL_ALU;
      end
   end

   assign set      = grant_alu | grant_ls;
   assign set_slot = grant_alu ? SLOT_W'(ALU_LAT - 1) : SLOT_W'(LS_LAT - 1);
   assign set_idx  = grant_alu ? in_rs_alu_rob_idx : in_rs_ls_rob_idx;

   fu_issue_sched_wb_slot_tracker #(
      .DEPTH  (MAX_LAT),
      .IDX_W  (ROB_IDX_W),
      .SLOT_W (SLOT_W)
   ) u_wb_slot_tracker (
      .clk       (in_clk),
      .rst_n     (in_rst_n),
      .set       (set),
      .set_slot  (set_slot),
      .set_idx   (set_idx),
      .flush     (in_flush),
      .slot_free (slot_free),
      .done      (out_rob_done),
      .idx       (out_rob_dst_rob_index)
   );

   assign out_rs_alu_grant = grant_alu;
   assign out_rs_ls_grant  = grant_ls;

endmodule

// File: tb/tb_fu_issue_sched.sv
// Directed bench for fu_issue_sched: one cycle per table row, hand-computed grants and writebacks.
module tb_fu_issue_sched;
   import fu_issue_sched_pkg::*;

   localparam int W = ROB_IDX_SIZE;

   logic         clk;
   logic         rst_n;
   logic         alu_req;
   logic [W-1:0] alu_idx;
   logic         ls_req;
   logic [W-1:0] ls_idx;
   logic         flush;
   logic         alu_grant;
   logic         ls_grant;
   logic         rob_done;
   logic [W-1:0] rob_idx;

   int tests_run = 0;
   int tests_failed = 0;

   fu_issue_sched dut (
      .in_clk                (clk),
      .in_rst_n              (rst_n),
      .in_rs_alu_req         (alu_req),
      .in_rs_alu_rob_idx     (alu_idx),
      .in_rs_ls_req          (ls_req),
      .in_rs_ls_rob_idx      (ls_idx),
      .in_flush              (flush),
      .out_rs_alu_grant      (alu_grant),
      .out_rs_ls_grant       (ls_grant),
      .out_rob_done          (rob_done),
      .out_rob_dst_rob_index (rob_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called one time unit after a rising edge; returns one time unit after the next one.
   task automatic cyc(input string name,
                      input logic ar, input logic [W-1:0] ai,
                      input logic lr, input logic [W-1:0] li,
                      input logic fl,
                      input logic e_ga, input logic e_gl,
                      input logic e_done, input logic [W-1:0] e_idx);
      alu_req = ar; alu_idx = ai; ls_req = lr; ls_idx = li; flush = fl;
      @(negedge clk);
      $display("[TB] %s: alu_grant=%0d ls_grant=%0d done=%0d idx=%0d",
               name, alu_grant, ls_grant, rob_done, rob_idx);
      check_eq({name, " alu_grant"}, {31'd0, alu_grant}, {31'd0, e_ga});
      check_eq({name, " ls_grant"},  {31'd0, ls_grant},  {31'd0, e_gl});
      check_eq({name, " done"},      {31'd0, rob_done},  {31'd0, e_done});
      if (e_done) check_eq({name, " idx"}, 32'(rob_idx), 32'(e_idx));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      alu_req = 1'b0; alu_idx = '0; ls_req = 1'b0; ls_idx = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      cyc("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("reset_idx", 32'(rob_idx), 32'd0);

      // 1: lone ALU op
      cyc("t1_c0", 1, 3, 0, 0, 0, 1, 0, 0, 0);
      cyc("t1_c1", 0, 0, 0, 0, 0, 0, 0, 1, 3);
      cyc("t1_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 2: LS then ALU collides on the bus
      do_reset();
      cyc("t2_c0", 0, 0, 1, 5, 0, 0, 1, 0, 0);
      cyc("t2_c1", 1, 6, 0, 0, 0, 0, 0, 0, 0);
      cyc("t2_c2", 1, 6, 0, 0, 0, 1, 0, 1, 5);
      cyc("t2_c3", 0, 0, 0, 0, 0, 0, 0, 1, 6);
      cyc("t2_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 3: both held -> ALU, LS, bubble, ...
      do_reset();
      cyc("t3_c0", 1, 1, 1, 2, 0, 1, 0, 0, 0);
      cyc("t3_c1", 1, 1, 1, 2, 0, 0, 1, 1, 1);
      cyc("t3_c2", 1, 1, 1, 2, 0, 0, 0, 0, 0);
      cyc("t3_c3", 1, 1, 1, 2, 0, 1, 0, 1, 2);
      cyc("t3_c4", 1, 1, 1, 2, 0, 0, 1, 1, 1);
      cyc("t3_c5", 1, 1, 1, 2, 0, 0, 0, 0, 0);
      cyc("t3_c6", 1, 1, 1, 2, 0, 1, 0, 1, 2);
      cyc("t3_c7", 0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc("t3_c8", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 4: back-to-back ALU
      do_reset();
      cyc("t4_c0", 1, 2, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4_c1", 1, 2, 0, 0, 0, 1, 0, 1, 2);
      cyc("t4_c2", 1, 2, 0, 0, 0, 1, 0, 1, 2);
      cyc("t4_c3", 1, 2, 0, 0, 0, 1, 0, 1, 2);
      cyc("t4_c4", 0, 0, 0, 0, 0, 0, 0, 1, 2);
      cyc("t4_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 5: flush squashes LS writeback and frees the bus
      do_reset();
      cyc("t5_c0", 0, 0, 1, 5, 0, 0, 1, 0, 0);
      cyc("t5_c1", 1, 6, 0, 0, 1, 0, 0, 0, 0);
      cyc("t5_c2", 1, 6, 0, 0, 0, 1, 0, 0, 0);
      cyc("t5_c3", 0, 0, 0, 0, 0, 0, 0, 1, 6);
      cyc("t5_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 6: async reset with both slots reserved
      do_reset();
      cyc("t6_c0", 0, 0, 1, 7, 0, 0, 1, 0, 0);
      cyc("t6_c1", 0, 0, 1, 8, 0, 0, 1, 0, 0);
      alu_req = 1'b1; alu_idx = 4; ls_req = 1'b1; ls_idx = 9; flush = 1'b0;
      #1;
      check_eq("t6_pre_done",   {31'd0, rob_done},  32'd1);
      check_eq("t6_pre_idx",    32'(rob_idx),       32'd7);
      check_eq("t6_pre_ls_gnt", {31'd0, ls_grant},  32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      $display("[TB] t6_async_rst: alu_grant=%0d ls_grant=%0d done=%0d idx=%0d",
               alu_grant, ls_grant, rob_done, rob_idx);
      check_eq("t6_rst_done",      {31'd0, rob_done},  32'd0);
      check_eq("t6_rst_idx",       32'(rob_idx),       32'd0);
      check_eq("t6_rst_alu_grant", {31'd0, alu_grant}, 32'd0);
      check_eq("t6_rst_ls_grant",  {31'd0, ls_grant},  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("t6_c3", 1, 4, 1, 9, 0, 1, 0, 0, 0);
      cyc("t6_c4", 1, 4, 1, 9, 0, 0, 1, 1, 4);
      cyc("t6_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t6_c6", 0, 0, 0, 0, 0, 0, 0, 1, 9);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
